// File: rtl/trigger_responder.sv
// Slave side of the trigger/done handshake: runs a fixed-length accumulate job
// per request and keeps one request pending while busy.
module trigger_responder #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] step,
    output logic             done,
    output logic [WIDTH-1:0] slave_out,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       job_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_op_q, pend_op_d;
    logic [WIDTH-1:0] pend_step_q, pend_step_d;
    logic [WIDTH-1:0] slave_out_q, slave_out_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       job_count_q, job_count_d;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum = acc_q + step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            step_q       <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= '0;
            pend_step_q  <= '0;
            slave_out_q  <= '0;
            overrun_q    <= 1'b0;
            job_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_step_q  <= pend_step_d;
            slave_out_q  <= slave_out_d;
            overrun_q    <= overrun_d;
            job_count_q  <= job_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_step_d  = pend_step_q;
        slave_out_d  = slave_out_q;
        overrun_d    = overrun_q;
        job_count_d  = job_count_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    acc_d   = operand;
                    step_d  = step;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (cnt_q == 8'd0) begin
                    slave_out_d = acc_sum;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
                // One request may wait in the slot; anything beyond is lost.
                if (trigger) begin
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_op_d    = operand;
                        pend_step_d  = step;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DONE: begin
                job_count_d = job_count_q + 8'd1;
                if (pend_valid_q) begin
                    acc_d        = pend_op_q;
                    step_d       = pend_step_q;
                    cnt_d        = CNT_INIT;
                    state_d      = RUN;
                    pend_valid_d = trigger;
                    if (trigger) begin
                        pend_op_d   = operand;
                        pend_step_d = step;
                    end
                end else if (trigger) begin
                    acc_d   = operand;
                    step_d  = step;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign slave_out = slave_out_q;
    assign overrun   = overrun_q;
    assign job_count = job_count_q;

endmodule

// File: tb/tb_trigger_responder.sv
// Directed bench for trigger_responder (WIDTH=4, LATENCY=8); edge E0 is the
// edge that samples the trigger, outputs are sampled 1ns after each edge.
module tb_trigger_responder;

    logic       clk;
    logic       rst;
    logic       trigger;
    logic [3:0] operand;
    logic [3:0] step;
    logic       done;
    logic [3:0] slave_out;
    logic       busy;
    logic       overrun;
    logic [7:0] job_count;

    int   checks;
    int   failures;
    int   done_cnt;
    logic busy_low;

    trigger_responder #(.WIDTH(4), .LATENCY(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .operand   (operand),
        .step      (step),
        .done      (done),
        .slave_out (slave_out),
        .busy      (busy),
        .overrun   (overrun),
        .job_count (job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (!busy) busy_low = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request for exactly one sampling edge (that edge is E0).
    task automatic pulse(input logic [3:0] op, input logic [3:0] st);
        trigger = 1'b1;
        operand = op;
        step    = st;
        tick();
        trigger = 1'b0;
        operand = 4'd0;
        step    = 4'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        busy_low = 1'b0;
        rst      = 1'b1;
        trigger  = 1'b0;
        operand  = 4'd0;
        step     = 4'd0;

        ticks(3);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_slave_out", 32'(slave_out), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_job_count", 32'(job_count), 0);
        rst = 1'b0;
        tick();

        // Basic job: 3 + 8*1 = 11
        pulse(4'd3, 4'd1);
        chk("basic_busy_e0", 32'(busy), 1);
        ticks(7);
        chk("basic_done_e7", 32'(done), 0);
        tick();
        chk("basic_done_e8", 32'(done), 1);
        chk("basic_result", 32'(slave_out), 11);
        tick();
        chk("basic_done_e9", 32'(done), 0);
        chk("basic_busy_e9", 32'(busy), 0);
        chk("basic_job_count", 32'(job_count), 1);
        chk("basic_result_held", 32'(slave_out), 11);

        // Wrap-around: (15 + 24) mod 16 = 7
        pulse(4'd15, 4'd3);
        ticks(8);
        chk("wrap_done", 32'(done), 1);
        chk("wrap_result", 32'(slave_out), 7);
        tick();
        chk("wrap_job_count", 32'(job_count), 2);

        // Pending capture: A at E0, B at E3
        pulse(4'd0, 4'd1);
        ticks(2);
        pulse(4'd2, 4'd2);
        ticks(5);
        chk("pend_a_done", 32'(done), 1);
        chk("pend_a_result", 32'(slave_out), 8);
        tick();
        chk("pend_gap_done", 32'(done), 0);
        chk("pend_gap_busy", 32'(busy), 1);
        ticks(7);
        chk("pend_b_early", 32'(done), 0);
        tick();
        chk("pend_b_done", 32'(done), 1);
        chk("pend_b_result", 32'(slave_out), 2);
        tick();
        chk("pend_busy_after", 32'(busy), 0);
        chk("pend_overrun", 32'(overrun), 0);
        chk("pend_job_count", 32'(job_count), 4);

        // Overrun: requests at E0, E2, E4; the third is dropped
        pulse(4'd1, 4'd1);
        tick();
        pulse(4'd5, 4'd0);
        tick();
        chk("ovr_before_third", 32'(overrun), 0);
        done_cnt = 0;
        pulse(4'd9, 4'd9);
        chk("ovr_set", 32'(overrun), 1);
        ticks(30);
        chk("ovr_done_pulses", 32'(done_cnt), 2);
        chk("ovr_last_result", 32'(slave_out), 5);
        chk("ovr_job_count", 32'(job_count), 6);
        chk("ovr_sticky", 32'(overrun), 1);

        // Trigger exactly on the DONE edge with an empty slot
        busy_low = 1'b0;
        done_cnt = 0;
        pulse(4'd2, 4'd1);
        ticks(8);
        chk("dcyc_first_done", 32'(done), 1);
        chk("dcyc_first_result", 32'(slave_out), 10);
        pulse(4'd4, 4'd3);
        chk("dcyc_restart_done", 32'(done), 0);
        ticks(7);
        chk("dcyc_second_early", 32'(done), 0);
        tick();
        chk("dcyc_second_done", 32'(done), 1);
        chk("dcyc_second_result", 32'(slave_out), 12);
        chk("dcyc_busy_held", 32'(busy_low), 0);
        chk("dcyc_done_pulses", 32'(done_cnt), 2);
        tick();
        chk("dcyc_busy_after", 32'(busy), 0);
        chk("dcyc_job_count", 32'(job_count), 8);

        // Reset at E4 of a job with a request pending
        pulse(4'd1, 4'd2);
        tick();
        pulse(4'd3, 4'd3);
        ticks(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_slave_out", 32'(slave_out), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_job_count", 32'(job_count), 0);
        ticks(2);
        rst = 1'b0;
        done_cnt = 0;
        ticks(20);
        chk("mid_rst_no_done", 32'(done_cnt), 0);
        chk("mid_rst_idle", 32'(busy), 0);
        pulse(4'd6, 4'd1);
        ticks(7);
        chk("post_rst_early", 32'(done), 0);
        tick();
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_result", 32'(slave_out), 14);
        tick();
        chk("post_rst_job_count", 32'(job_count), 1);
        chk("post_rst_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
